div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 64-bit integer divider that acts as the responder for EXU divide/remainder requests (DIV/DIVU/REM/REMU and the W variants).
- EXU issues operands plus op flags over a valid/ready request channel.
- The block runs a radix-2 restoring division and returns the result over a valid/ready response channel.
- The result then feeds the writeback mux alongside the ALU result.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  abort current operation (pipeline redirect)
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_src1  input  64  dividend (rs1 value)
- in_src2  input  64  divisor (rs2 value)
- in_is_signed  input  1  1 = DIV/REM(W), 0 = DIVU/REMU(W)
- in_is_rem  input  1  1 = return remainder, 0 = quotient
- in_is_word  input  1  1 = W variant, uses operand bits [31:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  64  quotient or remainder
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0, counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands and flags, then go to CALC, or to DONE for special cases when DIV_EARLY_OUT_EN is defined.
  - CALC: one quotient bit per cycle, MSB first. Counter loads N=64, or N=32 when is_word, and decrements each cycle. When the counter reaches 0, the final fix-up is applied and the state goes to DONE.
  - DONE: out_valid=1 and out_result is held stable. On out_ready, go to IDLE.
- Latency:
  - Acceptance edge is cycle 0.
  - out_valid rises at cycle N+1: 65 cycles for 64-bit ops, 33 for word ops.
  - in_ready is 0 from the cycle after acceptance until the return to IDLE. No new request is accepted in the same cycle a result is consumed.
- Operand preparation:
  - is_word: operands are taken from [31:0], sign-extended if is_signed, else zero-extended.
  - Signed ops: operands are converted to magnitudes, and the negation flags are recorded. Quotient sign = sign(src1) XOR sign(src2). Remainder sign = sign(src1).
- Result:
  - Word ops: the 32-bit result is sign-extended to 64 bits, for both signed and unsigned variants.
  - 64-bit ops: the full 64-bit result is returned.
- Special cases (RISC-V M extension, width per is_word):
  - Divide by zero: quotient = all ones; remainder = dividend, after the word sign-extension rule.
  - Signed overflow (most negative / -1): quotient = dividend; remainder = 0.
- Backpressure: while out_ready=0, the block stays in DONE holding out_result.
- Flush (priority below rst, above everything else):
  - Forces IDLE and drops out_valid the next cycle, in any state.
  - A request presented in the same cycle as flush is not accepted.
- Simultaneous in_valid and rst: reset wins and nothing is latched.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases go IDLE->DONE directly, so out_valid rises at cycle 1.
- Not defined: these cases still run the full N-cycle CALC, and the special-case result is substituted at fix-up, so latency is identical for all operands.

Test Plan:
- Unsigned 64-bit: src1=100, src2=7, is_rem=0 -> out_result=14 with out_valid at cycle 65. Repeat with is_rem=1 -> 2.
- Signed remainder: src1=-7, src2=2, signed, rem -> out_result=0xFFFF_FFFF_FFFF_FFFF (-1). Same operands with div -> -3.
- Divide by zero: src1=0x1234, src2=0, DIVU -> all ones; REMU -> 0x1234. Latency is 65 without DIV_EARLY_OUT_EN and 1 with it.
- Overflow: src1=0x8000_0000_0000_0000, src2=-1, DIV -> 0x8000_0000_0000_0000; REM -> 0.
- Word op: DIVW with src1=0xFFFF_FFFF_8000_0000, src2=0x0000_0000_0000_0002 -> 0xFFFF_FFFF_C000_0000 with out_valid at cycle 33. DIVUW on the same operands -> 0x0000_0000_4000_0000.
- Control:
  - Flush at cycle 10 of CALC -> IDLE next cycle with out_valid never asserted, and the next request completes correctly.
  - out_ready held low 5 cycles in DONE -> out_result stable and in_ready stays 0 throughout.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants.
// Latency: the request is accepted at edge 0; out_valid is high after edge N (N=64, or 32 for W ops).
// Backpressure: holds DONE and out_result while out_ready=0; in_ready=0 whenever not IDLE.
//
// Ports: clk/rst (sync, active-high), flush (abort to IDLE), in_* request channel
//        (valid/ready, src1/src2 operands, is_signed/is_rem/is_word flags),
//        out_* response channel (valid/ready, 64-bit result), busy (state != IDLE).
// Optional: define DIV_EARLY_OUT_EN so that divide-by-zero and signed overflow go
//           straight from IDLE to DONE. Without it, every operand takes N CALC cycles.
module div_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            in_is_signed,
  input  logic            in_is_rem,
  input  logic            in_is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;      // partial remainder
  logic [XLEN-1:0]  quo_q, quo_d;      // dividend shifts out of the top, quotient bits in at the bottom
  logic [XLEN-1:0]  div_q, div_d;      // divisor magnitude
  logic [XLEN-1:0]  a_q, a_d;          // width-extended dividend, used by the special-case results
  logic             neg_q_q, neg_q_d;  // quotient must be negated
  logic             neg_r_q, neg_r_d;  // remainder must be negated
  logic             is_rem_q, is_rem_d;
  logic             is_word_q, is_word_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [XLEN-1:0]  result_q, result_d;

  // Operand preparation from the request inputs
  logic [XLEN-1:0] src1_ext, src2_ext, a_mag, b_mag;
  logic            a_neg, b_neg, in_div0, in_ovf;

  always_comb begin
    if (in_is_word) begin
      src1_ext = in_is_signed ? {{32{in_src1[31]}}, in_src1[31:0]} : {32'b0, in_src1[31:0]};
      src2_ext = in_is_signed ? {{32{in_src2[31]}}, in_src2[31:0]} : {32'b0, in_src2[31:0]};
    end else begin
      src1_ext = in_src1;
      src2_ext = in_src2;
    end
    a_neg   = in_is_signed & src1_ext[XLEN-1];
    b_neg   = in_is_signed & src2_ext[XLEN-1];
    // Negating the most negative value yields itself, which is the correct unsigned magnitude.
    a_mag   = a_neg ? -src1_ext : src1_ext;
    b_mag   = b_neg ? -src2_ext : src2_ext;
    in_div0 = (src2_ext == '0);
    in_ovf  = in_is_signed & (in_is_word
              ? ((in_src1[31:0] == 32'h8000_0000) && (in_src2[31:0] == 32'hFFFF_FFFF))
              : ((in_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_src2 == '1)));
  end

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  logic [XLEN:0]   trial, diff;
  logic [XLEN-1:0] rem_it, quo_it;

  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, div_q};
    // The partial remainder is below the divisor, so whichever value is kept fits in XLEN bits.
    if (!diff[XLEN]) begin
      rem_it = diff[XLEN-1:0];
      quo_it = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_it = trial[XLEN-1:0];
      quo_it = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up, special-case substitution and W-result sign extension.
  function automatic logic [XLEN-1:0] finalize(
    input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem, input logic [XLEN-1:0] a,
    input logic neg_q, input logic neg_r, input logic is_rem, input logic is_word,
    input logic div0, input logic ovf);
    logic [XLEN-1:0] raw;
    if (div0)     raw = is_rem ? a : '1;
    else if (ovf) raw = is_rem ? '0 : a;
    else          raw = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    return is_word ? {{32{raw[31]}}, raw[31:0]} : raw;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      a_q       <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      a_q       <= a_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      is_rem_q  <= is_rem_d;
      is_word_q <= is_word_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    a_d       = a_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    is_rem_d  = is_rem_q;
    is_word_d = is_word_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d   = S_CALC;
            cnt_d     = in_is_word ? CNT_W'(32) : CNT_W'(XLEN);
            rem_d     = '0;
            // W dividends sit in the upper half so the MSB-first shift sees bit 31 first.
            quo_d     = in_is_word ? {a_mag[31:0], 32'b0} : a_mag;
            div_d     = b_mag;
            a_d       = src1_ext;
            neg_q_d   = a_neg ^ b_neg;
            neg_r_d   = a_neg;
            is_rem_d  = in_is_rem;
            is_word_d = in_is_word;
            div0_d    = in_div0;
            ovf_d     = in_ovf;
`ifdef DIV_EARLY_OUT_EN
            if (in_div0 || in_ovf) begin
              state_d  = S_DONE;
              cnt_d    = '0;
              result_d = finalize('0, '0, src1_ext, 1'b0, 1'b0, in_is_rem, in_is_word,
                                  in_div0, in_ovf);
            end
`else
`endif
          end
        end
        S_CALC: begin
          rem_d = rem_it;
          quo_d = quo_it;
          cnt_d = cnt_q - 1'b1;
          // Fix-up is folded into the step that takes the counter to zero.
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            result_d = finalize(quo_it, rem_it, a_q, neg_q_q, neg_r_q, is_rem_q, is_word_q,
                                div0_q, ovf_q);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    out_result = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Latency is counted as 1 plus the number of rising edges after the acceptance edge
// until out_valid is seen, so a result present right after the acceptance edge reads 1.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        in_is_signed;
  logic        in_is_rem;
  logic        in_is_word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 65;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2),
    .in_is_signed(in_is_signed), .in_is_rem(in_is_rem), .in_is_word(in_is_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  // Issues one request, waits for the result and consumes it. lat = -1 on timeout.
  task automatic do_op(input logic [63:0] s1, input logic [63:0] s2, input logic sg,
                       input logic rm, input logic wd, output logic [63:0] res,
                       output int lat);
    @(negedge clk);
    in_src1 = s1; in_src2 = s2; in_is_signed = sg; in_is_rem = rm; in_is_word = wd;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res = out_result;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_src1 = 64'd100; in_src2 = 64'd7;
    in_is_signed = 1'b0; in_is_rem = 1'b0; in_is_word = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, want 1 0 0 0",
               in_ready, out_valid, busy, out_result);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_latch: busy=%b want 0", busy);
    end
  endtask

  task automatic test_unsigned;
    logic [63:0] r; int lat;
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'd14) begin errors++; $display("FAIL divu_100_7: got %h want %h", r, 64'd14); end
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL divu_latency: got %0d want 65", lat); end
    do_op(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== 64'd2) begin errors++; $display("FAIL remu_100_7: got %h want %h", r, 64'd2); end
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'h5555_5555_5555_5555) begin
      errors++; $display("FAIL divu_max_3: got %h want 5555555555555555", r);
    end
  endtask

  task automatic test_signed;
    logic [63:0] r; int lat;
    do_op(-64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL rem_m7_2: got %h want ffffffffffffffff", r);
    end
    do_op(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_m7_2: got %h want fffffffffffffffd", r);
    end
    do_op(64'd7, -64'sd2, 1'b1, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_7_m2: got %h want fffffffffffffffd", r);
    end
  endtask

  task automatic test_div_zero;
    logic [63:0] r; int lat;
    do_op(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL divu_by_zero: got %h want ffffffffffffffff", r);
    end
    checks++;
    if (lat !== SPECIAL_LAT) begin
      errors++; $display("FAIL div_zero_latency: got %0d want %0d", lat, SPECIAL_LAT);
    end
    do_op(64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== 64'h1234) begin errors++; $display("FAIL remu_by_zero: got %h want 1234", r); end
    // REMUW by zero returns the 32-bit dividend sign-extended.
    do_op(64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b1, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_8000_0001) begin
      errors++; $display("FAIL remuw_by_zero: got %h want ffffffff80000001", r);
    end
  endtask

  task automatic test_overflow;
    logic [63:0] r; int lat;
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL div_overflow: got %h want 8000000000000000", r);
    end
    checks++;
    if (lat !== SPECIAL_LAT) begin
      errors++; $display("FAIL ovf_latency: got %0d want %0d", lat, SPECIAL_LAT);
    end
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== 64'd0) begin errors++; $display("FAIL rem_overflow: got %h want 0", r); end
  endtask

  task automatic test_word;
    logic [63:0] r; int lat;
    do_op(64'hFFFF_FFFF_8000_0000, 64'd2, 1'b1, 1'b0, 1'b1, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_C000_0000) begin
      errors++; $display("FAIL divw: got %h want ffffffffc0000000", r);
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL divw_latency: got %0d want 33", lat); end
    do_op(64'hFFFF_FFFF_8000_0000, 64'd2, 1'b0, 1'b0, 1'b1, r, lat);
    checks++;
    if (r !== 64'h0000_0000_4000_0000) begin
      errors++; $display("FAIL divuw: got %h want 0000000040000000", r);
    end
    // REMW: -7 rem 3 in 32 bits, upper operand bits ignored.
    do_op(64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0003, 1'b1, 1'b1, 1'b1, r, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL remw: got %h want ffffffffffffffff", r);
    end
  endtask

  task automatic test_flush;
    logic [63:0] r; int lat; int seen;
    seen = 0;
    @(negedge clk);
    in_src1 = 64'd100; in_src2 = 64'd7; in_is_signed = 1'b0; in_is_rem = 1'b0;
    in_is_word = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL accept_busy: in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b want 0 1 0",
               busy, in_ready, out_valid);
    end
    repeat (70) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_valid: saw %0d valid cycles want 0", seen); end
    // A request coinciding with flush must be dropped.
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: busy=%b want 0", busy); end
    do_op(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== 64'd2) begin errors++; $display("FAIL after_flush: got %h want 2", r); end
  endtask

  task automatic test_backpressure;
    int n; int bad;
    bad = 0;
    @(negedge clk);
    in_src1 = 64'd1000; in_src2 = 64'd9; in_is_signed = 1'b0; in_is_rem = 1'b0;
    in_is_word = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      if (out_result !== 64'd111 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bad !== 0 || out_result !== 64'd111) begin
      errors++; $display("FAIL bp_hold: %0d bad cycles, result %h want 6f", bad, out_result);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r; int lat;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== 64'h0FFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL b2b_first: got %h want 0fffffffffffffff", r);
    end
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== 64'hF) begin errors++; $display("FAIL b2b_second: got %h want f", r); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_word();
    test_flush();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
